// File: rtl/mac_seq_unit_if.sv
// Operand stream between the operand source (buffer/DMA) and the MAC
// sequencer: a signed operand pair qualified by a valid/ready handshake.
interface mac_seq_unit_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;

    // Operand source side.
    modport master (
        output in_valid,
        output a,
        output b,
        input  in_ready
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output in_ready
    );
endinterface

// File: rtl/mac_seq_unit.sv
// Programmable-length signed multiply-accumulate sequencer. A job is started
// in IDLE with a beat count, consumes that many operand pairs from the stream
// in RUN, and reports completion with a one-cycle done pulse from DONE. The
// accumulator either saturates or wraps at ACC_W bits; any overflow during a
// job is remembered in a sticky flag until the next accepted start.
// ACC_W must be at least 2*DATA_W so a single product always fits.
module mac_seq_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    abort,
    mac_seq_unit_if.slave           opnd,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        count,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        count_q;
    logic [LEN_W-1:0]        count_nxt;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]          sum_wide;
    logic                    ovf_beat;
    logic                    ovf_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    start_ok;
    logic                    accept;
    logic                    last_beat;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_sext(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(x) * PROD_W'(y);
        return ACC_W'(prod);
    endfunction

    // One guard bit above the accumulator so signed overflow is observable.
    function automatic logic [ACC_W:0] add_wide(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] y
    );
        return {x[ACC_W-1], x} + {y[ACC_W-1], y};
    endfunction

    // The ACC_W-bit result overflowed when the guard bit and sign bit differ.
    function automatic logic sum_ovf(input logic [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // Clamp to the signed limits when saturating; otherwise keep the low
    // ACC_W bits, which is the modulo-2^ACC_W wrap. The guard bit carries the
    // true sign, so it picks the clamp direction.
    function automatic logic signed [ACC_W-1:0] sat_or_wrap(input logic [ACC_W:0] s);
        if (SAT_EN && sum_ovf(s)) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return $signed(s[ACC_W-1:0]);
    endfunction

    assign start_ok  = (state == IDLE) && start;
    assign accept    = (state == RUN) && opnd.in_valid && !abort;
    assign count_nxt = count_q + LEN_W'(1);
    assign last_beat = accept && (count_nxt == len_q);

    // Accumulator update candidate for the operand pair currently on the bus.
    always_comb begin
        sum_wide = add_wide(acc_q, mul_sext(opnd.a, opnd.b));
        acc_nxt  = sat_or_wrap(sum_wide);
        ovf_beat = sum_ovf(sum_wide);
    end

    // Next-state logic and the combinational ready; abort wins over a beat.
    always_comb begin
        state_nxt     = state;
        opnd.in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                opnd.in_ready = !abort;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    // Job registers: cleared by an accepted start, advanced by accepted beats,
    // otherwise held so results stay readable after DONE or abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (start_ok) begin
            len_q   <= len;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            acc_q   <= acc_nxt;
            count_q <= count_nxt;
            ovf_q   <= ovf_q | ovf_beat;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_seq_unit.sv
// Bench for mac_seq_unit. Three instances share one stimulus: a 40-bit
// saturating accumulator, and 32-bit saturating and wrapping accumulators.
module tb_mac_seq_unit;
    localparam int DW = 16;
    localparam int LW = 8;

    logic                 clk     = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start   = 1'b0;
    logic                 abort   = 1'b0;
    logic [LW-1:0]        len     = '0;
    logic                 v_valid = 1'b0;
    logic signed [DW-1:0] v_a     = '0;
    logic signed [DW-1:0] v_b     = '0;

    logic                 busy, done, ovf40;
    logic                 busy_s, done_s, ovf_s;
    logic                 busy_w, done_w, ovf_w;
    logic [LW-1:0]        count, count_s, count_w;
    logic signed [39:0]   acc40;
    logic signed [31:0]   acc_s, acc_w;

    int vectors     = 0;
    int miscompares = 0;

    mac_seq_unit_if #(.DATA_W(DW)) op40 ();
    mac_seq_unit_if #(.DATA_W(DW)) op_s ();
    mac_seq_unit_if #(.DATA_W(DW)) op_w ();

    assign op40.in_valid = v_valid;
    assign op40.a        = v_a;
    assign op40.b        = v_b;
    assign op_s.in_valid = v_valid;
    assign op_s.a        = v_a;
    assign op_s.b        = v_b;
    assign op_w.in_valid = v_valid;
    assign op_w.a        = v_a;
    assign op_w.b        = v_b;

    mac_seq_unit #(.DATA_W(DW), .ACC_W(40), .LEN_W(LW), .SAT_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
        .opnd(op40), .busy(busy), .done(done), .count(count),
        .acc_out(acc40), .overflow(ovf40)
    );

    mac_seq_unit #(.DATA_W(DW), .ACC_W(32), .LEN_W(LW), .SAT_EN(1'b1)) u_sat32 (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
        .opnd(op_s), .busy(busy_s), .done(done_s), .count(count_s),
        .acc_out(acc_s), .overflow(ovf_s)
    );

    mac_seq_unit #(.DATA_W(DW), .ACC_W(32), .LEN_W(LW), .SAT_EN(1'b0)) u_wrap32 (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
        .opnd(op_w), .busy(busy_w), .done(done_w), .count(count_w),
        .acc_out(acc_w), .overflow(ovf_w)
    );

    always #5 clk = ~clk;

    // Mathematical reference: exact sum, then clamp or reduce modulo 2^w.
    function automatic longint model_acc(input longint acc, input longint p,
                                         input int w, input bit sat, output bit ovf);
        longint mx, mn, s, m;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        m   = longint'(1) <<< w;
        s   = acc + p;
        ovf = (s > mx) || (s < mn);
        if (!ovf) return s;
        if (sat) return (s > mx) ? mx : mn;
        return (s > mx) ? s - m : s + m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v_valid = 1'b1;
        repeat (2) tick();
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        if (count !== '0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        if (acc40 !== '0) begin miscompares++; $display("FAIL rst_acc got %0h want 0", acc40); end
        if (ovf40 !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b want 0", ovf40); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", op40.in_ready); end
        reset_n = 1'b1;
        tick();
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got %b want 0", op40.in_ready); end
        v_valid = 1'b0;
    endtask

    task automatic test_basic();
        int ea[3] = '{2, -4, 7};
        int eb[3] = '{3, 5, -1};
        longint e = 0;
        bit o;
        start = 1'b1; len = LW'(3);
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            v_valid = 1'b1; v_a = DW'(ea[i]); v_b = DW'(eb[i]);
            #1;
            vectors++;
            if (op40.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready beat %0d got %b want 1", i, op40.in_ready); end
            tick();
            e = model_acc(e, longint'(ea[i] * eb[i]), 40, 1'b1, o);
            vectors += 3;
            if (acc40 !== 40'(e)) begin miscompares++; $display("FAIL basic_acc beat %0d got %0d want %0d", i, acc40, e); end
            if (count !== LW'(i + 1)) begin miscompares++; $display("FAIL basic_count beat %0d got %0d want %0d", i, count, i + 1); end
            if (done !== (i == 2)) begin miscompares++; $display("FAIL basic_done beat %0d got %b want %b", i, done, i == 2); end
        end
        vectors += 2;
        if (acc40 !== 40'hFF_FFFF_FFEB) begin miscompares++; $display("FAIL basic_final got %0h want ffffffffeb", acc40); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_done got %b want 0", op40.in_ready); end
        tick();
        v_valid = 1'b0;
        vectors += 3;
        if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_end got %b want 0", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b want 0", busy); end
        if (count !== LW'(3)) begin miscompares++; $display("FAIL basic_count_hold got %0d want 3", count); end
    endtask

    task automatic test_valid_gaps();
        bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int ec = 0;
        bit running, fin;
        start = 1'b1; len = LW'(4);
        tick();
        start = 1'b0;
        v_a = 16'sd1; v_b = 16'sd1;
        for (int k = 0; k < 8; k++) begin
            v_valid = pat[k];
            running = (ec < 4);
            #1;
            vectors++;
            if (op40.in_ready !== running) begin miscompares++; $display("FAIL gaps_ready cyc %0d got %b want %b", k, op40.in_ready, running); end
            tick();
            fin = 1'b0;
            if (running && pat[k]) begin
                ec++;
                fin = (ec == 4);
            end
            vectors += 3;
            if (count !== LW'(ec)) begin miscompares++; $display("FAIL gaps_count cyc %0d got %0d want %0d", k, count, ec); end
            if (acc40 !== 40'(ec)) begin miscompares++; $display("FAIL gaps_acc cyc %0d got %0d want %0d", k, acc40, ec); end
            if (done !== fin) begin miscompares++; $display("FAIL gaps_done cyc %0d got %b want %b", k, done, fin); end
        end
        v_valid = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1; len = LW'(5);
        tick();
        start = 1'b0;
        v_valid = 1'b1; v_a = 16'sd10; v_b = 16'sd10;
        repeat (2) tick();
        abort = 1'b1;
        #1;
        vectors++;
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", op40.in_ready); end
        tick();
        abort = 1'b0;
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", done); end
        if (acc40 !== 40'sd200) begin miscompares++; $display("FAIL abort_acc got %0d want 200", acc40); end
        if (count !== LW'(2)) begin miscompares++; $display("FAIL abort_count got %0d want 2", count); end
        tick();
        vectors += 2;
        if (count !== LW'(2)) begin miscompares++; $display("FAIL abort_idle_count got %0d want 2", count); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_idle_done got %b want 0", done); end
        v_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (acc40 !== 40'sd200) begin miscompares++; $display("FAIL abort_in_idle_acc got %0d want 200", acc40); end
        start = 1'b1; len = LW'(3);
        tick();
        start = 1'b0;
        vectors += 3;
        if (acc40 !== '0) begin miscompares++; $display("FAIL restart_acc got %0d want 0", acc40); end
        if (count !== '0) begin miscompares++; $display("FAIL restart_count got %0d want 0", count); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b want 1", busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_saturation();
        start = 1'b1; len = LW'(2);
        tick();
        start = 1'b0;
        v_valid = 1'b1; v_a = -16'sd32768; v_b = -16'sd32768;
        tick();
        vectors += 4;
        if (acc_s !== 32'h4000_0000) begin miscompares++; $display("FAIL sat_beat1 got %0h want 40000000", acc_s); end
        if (acc_w !== 32'h4000_0000) begin miscompares++; $display("FAIL wrap_beat1 got %0h want 40000000", acc_w); end
        if (ovf_s !== 1'b0) begin miscompares++; $display("FAIL sat_ovf1 got %b want 0", ovf_s); end
        if (ovf_w !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf1 got %b want 0", ovf_w); end
        tick();
        v_valid = 1'b0;
        vectors += 8;
        if (acc_s !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL sat_clamp got %0h want 7fffffff", acc_s); end
        if (ovf_s !== 1'b1) begin miscompares++; $display("FAIL sat_ovf2 got %b want 1", ovf_s); end
        if (acc_w !== 32'h8000_0000) begin miscompares++; $display("FAIL wrap_val got %0h want 80000000", acc_w); end
        if (ovf_w !== 1'b1) begin miscompares++; $display("FAIL wrap_ovf2 got %b want 1", ovf_w); end
        if (done_s !== 1'b1) begin miscompares++; $display("FAIL sat_done got %b want 1", done_s); end
        if (done_w !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b want 1", done_w); end
        if (acc40 !== 40'h00_8000_0000) begin miscompares++; $display("FAIL acc40_wide got %0h want 80000000", acc40); end
        if (ovf40 !== 1'b0) begin miscompares++; $display("FAIL acc40_ovf got %b want 0", ovf40); end
        tick();
        vectors += 2;
        if (ovf_s !== 1'b1) begin miscompares++; $display("FAIL sat_ovf_sticky got %b want 1", ovf_s); end
        if (busy_s !== 1'b0) begin miscompares++; $display("FAIL sat_busy_end got %b want 0", busy_s); end
        start = 1'b1; len = LW'(1);
        tick();
        start = 1'b0;
        vectors += 3;
        if (ovf_s !== 1'b0) begin miscompares++; $display("FAIL sat_ovf_clear got %b want 0", ovf_s); end
        if (ovf_w !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf_clear got %b want 0", ovf_w); end
        if (acc_s !== '0) begin miscompares++; $display("FAIL sat_acc_clear got %0h want 0", acc_s); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_zero_len_and_ignored_start();
        v_valid = 1'b1;
        start = 1'b1; len = LW'(0);
        tick();
        len = LW'(7);
        vectors += 4;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got %b want 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b want 0", busy); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_ready got %b want 0", op40.in_ready); end
        if (acc40 !== '0) begin miscompares++; $display("FAIL zero_acc got %0d want 0", acc40); end
        tick();
        start = 1'b0;
        vectors += 3;
        if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_end got %b want 0", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL start_in_done_busy got %b want 0", busy); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL start_in_done_ready got %b want 0", op40.in_ready); end
        v_valid = 1'b0;
        start = 1'b1; len = LW'(2);
        tick();
        len = LW'(7);
        v_valid = 1'b1; v_a = 16'sd5; v_b = 16'sd6;
        tick();
        vectors++;
        if (count !== LW'(1)) begin miscompares++; $display("FAIL run_start_count got %0d want 1", count); end
        tick();
        start = 1'b0;
        v_valid = 1'b0;
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL run_start_done got %b want 1", done); end
        if (count !== LW'(2)) begin miscompares++; $display("FAIL run_start_len got %0d want 2", count); end
        if (acc40 !== 40'sd60) begin miscompares++; $display("FAIL run_start_acc got %0d want 60", acc40); end
        tick();
    endtask

    task automatic test_async_reset();
        start = 1'b1; len = LW'(5);
        tick();
        start = 1'b0;
        v_valid = 1'b1; v_a = 16'sd3; v_b = 16'sd3;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done got %b want 0", done); end
        if (count !== '0) begin miscompares++; $display("FAIL arst_count got %0d want 0", count); end
        if (acc40 !== '0) begin miscompares++; $display("FAIL arst_acc got %0d want 0", acc40); end
        if (ovf40 !== 1'b0) begin miscompares++; $display("FAIL arst_ovf got %b want 0", ovf40); end
        if (op40.in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready got %b want 0", op40.in_ready); end
        v_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL arst_after_done got %b want 0", done); end
        start = 1'b1; len = LW'(1);
        tick();
        start = 1'b0;
        v_valid = 1'b1; v_a = 16'sd3; v_b = 16'sd4;
        #1;
        vectors++;
        if (op40.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_job_ready got %b want 1", op40.in_ready); end
        tick();
        v_valid = 1'b0;
        vectors += 3;
        if (acc40 !== 40'sd12) begin miscompares++; $display("FAIL arst_job_acc got %0d want 12", acc40); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL arst_job_done got %b want 1", done); end
        if (count !== LW'(1)) begin miscompares++; $display("FAIL arst_job_count got %0d want 1", count); end
        tick();
    endtask

    task automatic test_random();
        int     jl, ec, cyc;
        longint e40, es, ew, p;
        bit     o40, os, ow, o, fin, aborted;
        for (int j = 0; j < 40; j++) begin
            jl = int'($urandom_range(1, 12));
            start = 1'b1; len = LW'(jl);
            tick();
            start = 1'b0;
            e40 = 0; es = 0; ew = 0; o40 = 0; os = 0; ow = 0;
            ec = 0; cyc = 0; fin = 0; aborted = 0;
            while (!fin) begin
                if (cyc > 200) begin
                    vectors++; miscompares++;
                    $display("FAIL rand_timeout job %0d count %0d want %0d", j, count, jl);
                    break;
                end
                v_valid = ($urandom_range(0, 3) != 0);
                v_a = DW'($urandom);
                v_b = DW'($urandom);
                abort = ($urandom_range(0, 29) == 0);
                #1;
                vectors++;
                if (op40.in_ready !== !abort) begin miscompares++; $display("FAIL rand_ready job %0d got %b want %b", j, op40.in_ready, !abort); end
                tick();
                if (abort) begin
                    fin = 1'b1; aborted = 1'b1;
                end else if (v_valid) begin
                    p   = longint'(v_a) * longint'(v_b);
                    e40 = model_acc(e40, p, 40, 1'b1, o); o40 |= o;
                    es  = model_acc(es, p, 32, 1'b1, o);  os  |= o;
                    ew  = model_acc(ew, p, 32, 1'b0, o);  ow  |= o;
                    ec++;
                    fin = (ec == jl);
                end
                abort = 1'b0;
                vectors += 11;
                if (acc40 !== 40'(e40)) begin miscompares++; $display("FAIL rand_acc40 job %0d got %0d want %0d", j, acc40, e40); end
                if (acc_s !== 32'(es)) begin miscompares++; $display("FAIL rand_acc_sat job %0d got %0d want %0d", j, acc_s, es); end
                if (acc_w !== 32'(ew)) begin miscompares++; $display("FAIL rand_acc_wrap job %0d got %0d want %0d", j, acc_w, ew); end
                if (ovf40 !== o40) begin miscompares++; $display("FAIL rand_ovf40 job %0d got %b want %b", j, ovf40, o40); end
                if (ovf_s !== os) begin miscompares++; $display("FAIL rand_ovf_sat job %0d got %b want %b", j, ovf_s, os); end
                if (ovf_w !== ow) begin miscompares++; $display("FAIL rand_ovf_wrap job %0d got %b want %b", j, ovf_w, ow); end
                if (count !== LW'(ec)) begin miscompares++; $display("FAIL rand_count job %0d got %0d want %0d", j, count, ec); end
                if (count_w !== LW'(ec)) begin miscompares++; $display("FAIL rand_count_w job %0d got %0d want %0d", j, count_w, ec); end
                if (done !== (fin && !aborted)) begin miscompares++; $display("FAIL rand_done job %0d got %b want %b", j, done, fin && !aborted); end
                if (busy !== !fin) begin miscompares++; $display("FAIL rand_busy job %0d got %b want %b", j, busy, !fin); end
                if (busy_w !== !fin) begin miscompares++; $display("FAIL rand_busy_w job %0d got %b want %b", j, busy_w, !fin); end
                cyc++;
            end
            v_valid = 1'b0;
            tick();
            vectors += 3;
            if (done !== 1'b0) begin miscompares++; $display("FAIL rand_done_end job %0d got %b want 0", j, done); end
            if (count_s !== LW'(ec)) begin miscompares++; $display("FAIL rand_count_s_hold job %0d got %0d want %0d", j, count_s, ec); end
            if (acc40 !== 40'(e40)) begin miscompares++; $display("FAIL rand_acc_hold job %0d got %0d want %0d", j, acc40, e40); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_gaps();
        test_abort();
        test_saturation();
        test_zero_len_and_ignored_start();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule
